// File: rtl/matrix_input_writer_if.sv
// Element stream in, storage write channel and status out; slave = writer, master = driver.
interface matrix_input_writer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_elem_valid;
  logic [DATA_W-1:0] i_elem_data;
  logic              i_elem_last;
  logic              o_elem_ready;
  logic [ADDR_W-1:0] w_input_addr;
  logic [DATA_W-1:0] w_input_data;
  logic              w_input_we;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  modport slave (
    input  i_start, i_base_addr, i_elem_valid, i_elem_data, i_elem_last,
    output o_elem_ready, w_input_addr, w_input_data, w_input_we,
    output o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_base_addr, i_elem_valid, i_elem_data, i_elem_last,
    input  o_elem_ready, w_input_addr, w_input_data, w_input_we,
    input  o_busy, o_done, o_error
  );
endinterface

// File: rtl/matrix_input_writer.sv
// Streams rows, cols, then elements into storage (header at base, data at base+1..); writes one cycle after transfer.
// Ready only in GET_ROWS/GET_COLS/GET_ELEM; INPUT_ZERO_FILL_EN zero-fills after an early i_elem_last instead of erroring.
module matrix_input_writer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_input_writer_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_DIM * MAX_DIM + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ROWS  = 3'd1,
    GET_COLS  = 3'd2,
    WRITE_HDR = 3'd3,
    GET_ELEM  = 3'd4,
`ifdef INPUT_ZERO_FILL_EN
    FILL      = 3'd5,
`endif
    DONE      = 3'd6,
    ERR       = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         rows_q, rows_d;
  logic [7:0]         cols_q, cols_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               done_q;

  logic               xfer;
  logic [7:0]         dim_word;
  logic               dim_bad;
  logic [15:0]        elem_total;
  logic [15:0]        last_idx;
  logic               at_last;
  logic [ADDR_W-1:0]  elem_addr;
  logic [DATA_W-1:0]  hdr_word;

  assign xfer       = bus.i_elem_valid && bus.o_elem_ready;
  assign dim_word   = bus.i_elem_data[7:0];
  assign dim_bad    = (dim_word == 8'd0) || (dim_word > 8'(MAX_DIM));
  assign elem_total = 16'(rows_q) * 16'(cols_q);
  assign last_idx   = elem_total - 16'd1;
  assign at_last    = (16'(cnt_q) == last_idx);
  // Element k lives one past the header; the sum wraps naturally at 2^ADDR_W.
  assign elem_addr  = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);

  always_comb begin
    hdr_word       = '0;
    hdr_word[15:8] = rows_q;
    hdr_word[7:0]  = dim_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= (state_q == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      IDLE, ERR: begin
        if (bus.i_start) begin
          state_d = GET_ROWS;
          base_d  = bus.i_base_addr;
          cnt_d   = '0;
        end
      end

      GET_ROWS: begin
        if (xfer) begin
          rows_d = dim_word;
          if (bus.i_elem_last || dim_bad) state_d = ERR;
          else                            state_d = GET_COLS;
        end
      end

      GET_COLS: begin
        if (xfer) begin
          cols_d = dim_word;
          if (bus.i_elem_last || dim_bad) begin
            state_d = ERR;
          end else begin
            // Header is registered on the way in so we is high during WRITE_HDR.
            state_d = WRITE_HDR;
            we_d    = 1'b1;
            addr_d  = base_q;
            data_d  = hdr_word;
          end
        end
      end

      WRITE_HDR: state_d = GET_ELEM;

      GET_ELEM: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (at_last) begin
            we_d    = 1'b1;
            addr_d  = elem_addr;
            data_d  = bus.i_elem_data;
            state_d = DONE;
          end else if (bus.i_elem_last) begin
`ifdef INPUT_ZERO_FILL_EN
            we_d    = 1'b1;
            addr_d  = elem_addr;
            data_d  = bus.i_elem_data;
            state_d = FILL;
`else
            state_d = ERR;
`endif
          end else begin
            we_d   = 1'b1;
            addr_d = elem_addr;
            data_d = bus.i_elem_data;
          end
        end
      end

`ifdef INPUT_ZERO_FILL_EN
      FILL: begin
        we_d   = 1'b1;
        addr_d = elem_addr;
        data_d = '0;
        cnt_d  = cnt_q + CNT_W'(1);
        if (at_last) state_d = DONE;
      end
`endif

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_elem_ready = (state_q == GET_ROWS) || (state_q == GET_COLS) ||
                            (state_q == GET_ELEM);
  assign bus.o_busy       = (state_q != IDLE) && (state_q != ERR);
  assign bus.o_error      = (state_q == ERR);
  assign bus.o_done       = done_q;
  assign bus.w_input_we   = we_q;
  assign bus.w_input_addr = addr_q;
  assign bus.w_input_data = data_q;

  a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
    bus.o_elem_ready |-> bus.o_busy);
  a_err_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    bus.o_error |-> (!bus.w_input_we && !bus.o_busy));
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
    bus.o_done |-> !bus.o_busy);

endmodule

// File: tb/tb_matrix_input_writer.sv
// Table-driven sessions with a write scoreboard, plus an asynchronous mid-session reset sequence.
module tb_matrix_input_writer;

`ifdef INPUT_ZERO_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_input_writer_if #(.ADDR_W(8), .DATA_W(32)) bus();

  matrix_input_writer #(.ADDR_W(8), .DATA_W(32), .MAX_DIM(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [7:0]  base;
    int          rows;
    int          cols;
    int          last_at;   // word index carrying i_elem_last (0=rows,1=cols,2+k=elem k), -1 none
    bit          gap;
    bit          stray;
    logic [31:0] dbase;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  wr_t  exp_q[$];
  wr_t  e;
  int   done_cnt = 0;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},    64'(bus.w_input_we),   64'd0);
    chk({tag, "_addr"},  64'(bus.w_input_addr), 64'd0);
    chk({tag, "_data"},  64'(bus.w_input_data), 64'd0);
    chk({tag, "_ready"}, 64'(bus.o_elem_ready), 64'd0);
    chk({tag, "_busy"},  64'(bus.o_busy),       64'd0);
    chk({tag, "_done"},  64'(bus.o_done),       64'd0);
    chk({tag, "_error"}, 64'(bus.o_error),      64'd0);
  endtask

  // Write scoreboard and o_done timing monitor, sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.w_input_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write",
                 bus.w_input_addr, bus.w_input_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.w_input_addr), 64'(e.a));
        chk("wr_data", 64'(bus.w_input_data), 64'(e.d));
      end
    end
    if (bus.o_done) begin
      done_cnt++;
      chk("done_after_write", 64'(prev_we), 64'd1);
      chk("done_single", 64'(prev_done), 64'd0);
    end
    prev_we   = bus.w_input_we;
    prev_done = bus.o_done;
  end

  function automatic logic [31:0] word_of(input vec_t v, input int w);
    if (w == 0) return 32'h5A5A_5A00 | 32'(v.rows);
    if (w == 1) return 32'h3C3C_3C00 | 32'(v.cols);
    return v.dbase + 32'(w - 2);
  endfunction

  // Reference model: pushes expected writes, returns the number of words to offer.
  function automatic int model(input vec_t v);
    bit   ok;
    int   n, kl, nw;
    wr_t  w;
    ok = (v.rows >= 1) && (v.rows <= 5) && (v.cols >= 1) && (v.cols <= 5) &&
         (v.last_at != 0) && (v.last_at != 1);
    if (!ok) return 2;
    n  = v.rows * v.cols;
    kl = (v.last_at >= 2) ? v.last_at - 2 : -1;
    w.a = v.base;
    w.d = 32'((v.rows << 8) | v.cols);
    exp_q.push_back(w);
    if (kl >= 0 && kl < n - 1) begin
      nw = 2 + kl + 1;
      for (int k = 0; k < n; k++) begin
        w.a = v.base + 8'(1 + k);
        if (k <= kl) begin
          w.d = v.dbase + 32'(k);
          if (FILL_EN || k < kl) exp_q.push_back(w);
        end else if (FILL_EN) begin
          w.d = 32'd0;
          exp_q.push_back(w);
        end
      end
    end else begin
      nw = 2 + n;
      for (int k = 0; k < n; k++) begin
        w.a = v.base + 8'(1 + k);
        w.d = v.dbase + 32'(k);
        exp_q.push_back(w);
      end
    end
    return nw;
  endfunction

  task automatic start_pulse(input logic [7:0] base);
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_base_addr = base;
    @(negedge clk);
    bus.i_start     = 1'b0;
  endtask

  task automatic drive(input vec_t v, input int nw, output int sent);
    int w   = 0;
    int cyc = 0;
    while (w < nw && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.i_start     = v.stray && (w == 3);
      bus.i_base_addr = bus.i_start ? 8'h80 : v.base;
      if (bus.o_error) break;
      if (v.gap && (cyc % 2 == 0)) begin
        bus.i_elem_valid = 1'b0;
        bus.i_elem_last  = 1'b0;
        continue;
      end
      bus.i_elem_valid = 1'b1;
      bus.i_elem_data  = word_of(v, w);
      bus.i_elem_last  = (w == v.last_at);
      if (bus.o_elem_ready) w++;
    end
    @(negedge clk);
    bus.i_elem_valid = 1'b0;
    bus.i_elem_last  = 1'b0;
    bus.i_start      = 1'b0;
    sent = w;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nw, sent, d0, t;
    d0 = done_cnt;
    nw = model(v);
    start_pulse(v.base);
    drive(v, nw, sent);
    if (!v.exp_err) chk($sformatf("v%0d_words_sent", idx), 64'(sent), 64'(nw));
    t = 0;
    while (t < 100 && done_cnt == d0 && !bus.o_error) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("v%0d_outcome_seen", idx), 64'(t < 100), 64'd1);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_writes_left", idx), 64'(exp_q.size()), 64'd0);
    chk($sformatf("v%0d_done_count", idx), 64'(done_cnt - d0), 64'(v.exp_done));
    chk($sformatf("v%0d_error", idx), 64'(bus.o_error), 64'(v.exp_err));
    chk($sformatf("v%0d_busy", idx), 64'(bus.o_busy), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   sent, d0;
    vec_t rv;

    bus.i_start      = 1'b0;
    bus.i_base_addr  = '0;
    bus.i_elem_valid = 1'b0;
    bus.i_elem_data  = '0;
    bus.i_elem_last  = 1'b0;

    vecs[0]  = '{8'h10, 2, 3, -1, 1'b0, 1'b0, 32'd1,         1'b0, 1};
    vecs[1]  = '{8'h20, 6, 3, -1, 1'b0, 1'b0, 32'hC0DE_0100, 1'b1, 0};
    vecs[2]  = '{8'hFE, 2, 2, -1, 1'b0, 1'b0, 32'hC0DE_0200, 1'b0, 1};
    vecs[3]  = '{8'h30, 2, 2,  3, 1'b0, 1'b0, 32'hC0DE_0300, !FILL_EN, int'(FILL_EN)};
    vecs[4]  = '{8'h40, 3, 3, -1, 1'b1, 1'b0, 32'hC0DE_0400, 1'b0, 1};
    vecs[5]  = '{8'h50, 0, 2, -1, 1'b0, 1'b0, 32'hC0DE_0500, 1'b1, 0};
    vecs[6]  = '{8'h60, 3, 6, -1, 1'b0, 1'b0, 32'hC0DE_0600, 1'b1, 0};
    vecs[7]  = '{8'h70, 5, 5, 26, 1'b0, 1'b0, 32'hC0DE_0700, 1'b0, 1};
    vecs[8]  = '{8'h90, 2, 2, -1, 1'b0, 1'b1, 32'hC0DE_0800, 1'b0, 1};
    vecs[9]  = '{8'hA0, 2, 2,  0, 1'b0, 1'b0, 32'hC0DE_0900, 1'b1, 0};
    vecs[10] = '{8'hB0, 2, 3,  2, 1'b0, 1'b0, 32'hC0DE_0A00, !FILL_EN, int'(FILL_EN)};
    vecs[11] = '{8'hC0, 1, 1, -1, 1'b0, 1'b0, 32'hC0DE_0B00, 1'b0, 1};

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
      if (i == 0) begin
        chk("hold_we",   64'(bus.w_input_we),   64'd0);
        chk("hold_addr", 64'(bus.w_input_addr), 64'h16);
        chk("hold_data", 64'(bus.w_input_data), 64'd6);
      end
    end

    // Reset after two of four elements: outputs clear without a clock edge, no o_done.
    rv = '{8'hD0, 2, 2, -1, 1'b0, 1'b0, 32'hC0DE_0D00, 1'b0, 0};
    d0 = done_cnt;
    void'(model(rv));
    exp_q = exp_q[0:2];
    start_pulse(rv.base);
    drive(rv, 4, sent);
    chk("rst_seq_words_sent", 64'(sent), 64'd4);
    @(negedge clk);
    chk("rst_seq_busy_before", 64'(bus.o_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    chk("rst_seq_writes_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seq_no_done", 64'(done_cnt - d0), 64'd0);
    exp_q.delete();
    run_vec(12, vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
